instr_exec_reader: RTL and testbench
====================================

INSTR_EXEC_READER -- requirements
Module: instr_exec_reader

Interface
REQ-001 Parameter: ADDR_W, default 5; instruction register address width, 2**ADDR_W entries.
REQ-002 Parameter: OPND_W, default 32; signed operand width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a read/execute run.
REQ-007 start_addr  input  ADDR_W  first entry to read.
REQ-008 count  input  ADDR_W+1  number of entries to process, 0..2**ADDR_W.
REQ-009 read_pointer  output  ADDR_W  address driven to the instruction register read port.
REQ-010 instruction_word  input  4+2*OPND_W  packed {opcode[3:0], operand_a, operand_b}; combinational read data for read_pointer.
REQ-011 result  output  2*OPND_W  signed execution result.
REQ-012 result_addr  output  ADDR_W  entry the result came from.
REQ-013 result_err  output  1  illegal opcode or divide by zero.
REQ-014 result_valid / result_ready  output / input  1 / 1  result handshake.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 done  output  1  one-cycle pulse at run completion.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, EXEC, OUT.
REQ-018 In IDLE, start=1 with count>0 SHALL latch start_addr and count and move to FETCH; start with count=0 SHALL pulse done on the next cycle, with no results.
REQ-019 start SHALL be ignored while busy=1.
REQ-020 FETCH SHALL drive read_pointer = current address and register instruction_word at the clock edge, then move to EXEC.
REQ-021 EXEC SHALL compute and register result, result_addr and result_err, assert result_valid, and move to OUT.
REQ-022 Opcode semantics (operands sign-extended to 2*OPND_W):
- 0 ZERO -> 0.
- 1 PASSA -> a.
- 2 PASSB -> b.
- 3 ADD -> a+b.
- 4 SUB -> a-b.
- 5 MULT -> a*b, full signed product.
- 6 DIV -> a/b, truncating toward zero.
- 7 MOD -> a%b, remainder sign follows the dividend.
- 8..15 -> result 0, result_err=1.
REQ-023 DIV or MOD with b=0 SHALL give result 0 and result_err=1; otherwise result_err=0.
REQ-024 In OUT, result, result_addr and result_err SHALL hold stable while result_valid=1 and result_ready=0.
REQ-025 On an OUT edge with result_ready=1:
- Remaining count decrements.
- If remaining is nonzero: address increments modulo 2**ADDR_W, state moves to FETCH.
- Otherwise: result_valid drops, done pulses in the following cycle, state moves to IDLE.
REQ-026 Latency: with start sampled at edge k and result_ready held 1, the first result_valid SHALL be high after edge k+2, and each subsequent result SHALL follow 3 edges later.
REQ-027 Address wrap: start_addr=2**ADDR_W-1 with count>1 SHALL continue at address 0.
REQ-028 count=2**ADDR_W SHALL read every entry exactly once.

Reset
REQ-029 Reset SHALL force IDLE and clear the latched run state, overriding any operation in progress.
REQ-030 Reset values: read_pointer=0, result=0, result_addr=0, result_err=0, result_valid=0, busy=0, done=0.
REQ-031 Reset asserted mid-run SHALL discard the pending result, and no done pulse SHALL follow.

Configuration
REQ-032 Macro EXEC_MULDIV_EN.
- Defined: opcodes 5-7 SHALL execute per REQ-022 and REQ-023.
- Undefined: opcodes 5-7 SHALL behave as illegal (result 0, result_err=1), and no multiplier or divider SHALL be synthesized.

Verification
REQ-033 Entry 3 = {ADD, 5, -7}; start_addr=3, count=1, result_ready=1 -> result=-2, result_addr=3, result_err=0, valid after edge k+2, done one cycle after the handshake.
REQ-034 Entries 30, 31, 0 = {SUB,10,3}, {MULT,-4,6}, {PASSB,0,9}; start_addr=30, count=3 -> results 7, -24, 9 at addresses 30, 31, 0 (wrap).
REQ-035 Entry 0 = {DIV, 8, 0}, then entry 1 = {MOD, -7, 2}; start_addr=0, count=2 -> (0, err=1), then (-1, err=0).
REQ-036 result_ready held 0 for 5 cycles -> result_valid and result stay constant, and a start pulse during the wait is ignored.
REQ-037 Reset asserted in EXEC of a 4-entry run -> next cycle has all outputs at reset values, and no done pulse follows.
REQ-038 Build without EXEC_MULDIV_EN, entry {MULT, 2, 3} -> result=0, result_err=1.

Source files
------------

// File: rtl/instr_exec_reader_if.sv
// Bundle between a run controller / instruction store and the instruction
// reader-executor: run request, instruction read port, result handshake.
interface instr_exec_reader_if #(
   parameter int ADDR_W = 5,
   parameter int OPND_W = 32
);
   logic                       start;
   logic [ADDR_W-1:0]          start_addr;
   logic [ADDR_W:0]            count;
   logic [ADDR_W-1:0]          read_pointer;
   logic [3+2*OPND_W:0]        instruction_word;
   logic signed [2*OPND_W-1:0] result;
   logic [ADDR_W-1:0]          result_addr;
   logic                       result_err;
   logic                       result_valid;
   logic                       result_ready;
   logic                       busy;
   logic                       done;

   modport master (
      output start, start_addr, count, instruction_word, result_ready,
      input  read_pointer, result, result_addr, result_err, result_valid,
             busy, done
   );

   modport slave (
      input  start, start_addr, count, instruction_word, result_ready,
      output read_pointer, result, result_addr, result_err, result_valid,
             busy, done
   );
endinterface

// File: rtl/instr_exec_reader.sv
// Walks a run of instruction-register entries, executing one opcode per entry.
// Optional macro EXEC_MULDIV_EN enables MULT/DIV/MOD (opcodes 5-7).
module instr_exec_reader #(
   parameter int ADDR_W = 5,
   parameter int OPND_W = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   instr_exec_reader_if.slave   bus
);
   localparam int RES_W = 2 * OPND_W;
   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
   localparam logic [ADDR_W:0]   CNT_ONE  = 1;
   localparam logic [ADDR_W:0]   CNT_ZERO = 0;

   typedef enum logic [1:0] {IDLE, FETCH, EXEC, OUT} state_t;

   state_t                  state_reg, state_next;
   logic [ADDR_W-1:0]       addr_reg;
   logic [ADDR_W:0]         rem_reg;
   logic [3+RES_W:0]        instr_reg;
   logic signed [RES_W-1:0] result_reg, result_next;
   logic [ADDR_W-1:0]       result_addr_reg;
   logic                    err_reg, err_next;
   logic                    done_reg;

   logic start_run, start_empty, fetch_en, exec_en, out_fire, last_entry;
   logic [3:0]              opcode;
   logic signed [RES_W-1:0] a_ext, b_ext;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   assign last_entry = (rem_reg == CNT_ONE);

   // Next-state logic; start is only honoured from IDLE
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:  if (bus.start && bus.count != CNT_ZERO) state_next = FETCH;
         FETCH: state_next = EXEC;
         EXEC:  state_next = OUT;
         OUT:   if (bus.result_ready) state_next = last_entry ? IDLE : FETCH;
         default: state_next = IDLE;
      endcase
   end

   // Output / strobe decode
   always_comb begin
      bus.busy         = (state_reg != IDLE);
      bus.result_valid = (state_reg == OUT);
      start_run        = (state_reg == IDLE) && bus.start && (bus.count != CNT_ZERO);
      start_empty      = (state_reg == IDLE) && bus.start && (bus.count == CNT_ZERO);
      fetch_en         = (state_reg == FETCH);
      exec_en          = (state_reg == EXEC);
      out_fire         = (state_reg == OUT) && bus.result_ready;
   end

   assign opcode = instr_reg[3+RES_W -: 4];
   assign a_ext  = {{OPND_W{instr_reg[RES_W-1]}}, instr_reg[RES_W-1:OPND_W]};
   assign b_ext  = {{OPND_W{instr_reg[OPND_W-1]}}, instr_reg[OPND_W-1:0]};

   always_comb begin
      result_next = '0;
      err_next    = 1'b0;
      case (opcode)
         4'd0: result_next = '0;
         4'd1: result_next = a_ext;
         4'd2: result_next = b_ext;
         4'd3: result_next = a_ext + b_ext;
         4'd4: result_next = a_ext - b_ext;
`ifdef EXEC_MULDIV_EN
         // Operands are sign-extended first, so the 2*OPND_W product is exact
         4'd5: result_next = a_ext * b_ext;
         4'd6: begin
            if (b_ext == '0) err_next = 1'b1;
            else             result_next = a_ext / b_ext;
         end
         4'd7: begin
            if (b_ext == '0) err_next = 1'b1;
            else             result_next = a_ext % b_ext;
         end
`endif
         default: err_next = 1'b1;
      endcase
   end

   // Run bookkeeping and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_reg        <= '0;
         rem_reg         <= '0;
         instr_reg       <= '0;
         result_reg      <= '0;
         result_addr_reg <= '0;
         err_reg         <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         done_reg <= start_empty || (out_fire && last_entry);
         if (start_run) begin
            addr_reg <= bus.start_addr;
            rem_reg  <= bus.count;
         end else if (out_fire) begin
            rem_reg <= rem_reg - CNT_ONE;
            if (!last_entry) addr_reg <= addr_reg + ADDR_ONE;
         end
         if (fetch_en) instr_reg <= bus.instruction_word;
         if (exec_en) begin
            result_reg      <= result_next;
            result_addr_reg <= addr_reg;
            err_reg         <= err_next;
         end
      end
   end

   assign bus.read_pointer = addr_reg;
   assign bus.result       = result_reg;
   assign bus.result_addr  = result_addr_reg;
   assign bus.result_err   = err_reg;
   assign bus.done         = done_reg;
endmodule

// File: tb/tb_instr_exec_reader.sv
// Self-checking bench for instr_exec_reader: vector table, directed corner
// sequences and randomized runs against an arithmetic reference model.
module tb_instr_exec_reader;
   localparam int AW = 5;
   localparam int OW = 32;
   localparam int N  = 1 << AW;
`ifdef EXEC_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [63:0]   res;
      logic          err;
   } exp_t;

   typedef struct {
      logic [3:0] op;
      int         a;
      int         b;
      longint     res;
      bit         err;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   logic [3+2*OW:0] mem [N];
   exp_t exp_q [$];
   int   pass_cnt = 0;
   int   total_cnt = 0;

   always #5 clk = ~clk;

   instr_exec_reader_if #(.ADDR_W(AW), .OPND_W(OW)) bus ();

   instr_exec_reader #(.ADDR_W(AW), .OPND_W(OW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   assign bus.instruction_word = mem[bus.read_pointer];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else pass_cnt++;
   endtask

   task automatic push(input int addr, input longint res, input bit err);
      exp_t e;
      e.addr = AW'(addr);
      e.res  = res;
      e.err  = err;
      exp_q.push_back(e);
   endtask

   // Reference: sign-extended operands, plain 64-bit integer arithmetic
   function automatic exp_t model(input int addr);
      logic [3+2*OW:0] w = mem[addr];
      longint a = longint'($signed(w[63:32]));
      longint b = longint'($signed(w[31:0]));
      exp_t e;
      e.addr = AW'(addr);
      e.res  = '0;
      e.err  = 1'b0;
      case (w[67:64])
         4'd0: e.res = '0;
         4'd1: e.res = a;
         4'd2: e.res = b;
         4'd3: e.res = a + b;
         4'd4: e.res = a - b;
         4'd5: if (MD) e.res = a * b; else e.err = 1'b1;
         4'd6, 4'd7: begin
            if (!MD || b == 0) e.err = 1'b1;
            else e.res = (w[67:64] == 4'd6) ? a / b : a % b;
         end
         default: e.err = 1'b1;
      endcase
      return e;
   endfunction

   function automatic logic [3+2*OW:0] rand_word();
      logic [3:0] op = 4'($urandom_range(0, 15));
      int a = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 40)) - 20;
      int b = ($urandom_range(0, 5) == 0) ? 0 :
              ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 40)) - 20;
      return {op, a, b};
   endfunction

   // One run: start pulse, then every result checked against exp_q in order
   task automatic run(input int saddr, input int cnt, input int min_stall,
                      input int max_stall, input bit poke);
      exp_t e;
      int   n;
      int   stall;
      bus.start        = 1'b1;
      bus.start_addr   = AW'(saddr);
      bus.count        = (AW+1)'(cnt);
      bus.result_ready = 1'b1;
      tick();
      bus.start = 1'b0;
      if (cnt == 0) begin
         check("empty_done", 64'(bus.done), 64'd1);
         check("empty_valid", 64'(bus.result_valid), 64'd0);
         tick();
         check("empty_done_end", 64'(bus.done), 64'd0);
         return;
      end
      for (int i = 0; i < cnt; i++) begin
         n = 0;
         while (!bus.result_valid && n < 20) begin
            tick();
            n++;
         end
         check("latency", 64'(n), 64'd2);
         e = exp_q.pop_front();
         $display("xfer addr=%0d result=%0d err=%0b", bus.result_addr, bus.result, bus.result_err);
         check("result", bus.result, e.res);
         check("result_addr", 64'(bus.result_addr), 64'(e.addr));
         check("result_err", 64'(bus.result_err), 64'(e.err));
         check("busy", 64'(bus.busy), 64'd1);
         check("done_mid", 64'(bus.done), 64'd0);
         stall = int'($urandom_range(max_stall, min_stall));
         for (int s = 0; s < stall; s++) begin
            bus.result_ready = 1'b0;
            if (poke && s == 1) begin
               bus.start      = 1'b1;
               bus.start_addr = AW'(saddr + 7);
               bus.count      = (AW+1)'(1);
            end
            tick();
            bus.start = 1'b0;
            check("stall_valid", 64'(bus.result_valid), 64'd1);
            check("stall_result", bus.result, e.res);
            check("stall_addr", 64'(bus.result_addr), 64'(e.addr));
            check("stall_err", 64'(bus.result_err), 64'(e.err));
         end
         bus.result_ready = 1'b1;
         tick();
         if (i == cnt - 1) begin
            check("done_pulse", 64'(bus.done), 64'd1);
            check("valid_drop", 64'(bus.result_valid), 64'd0);
            tick();
            check("done_end", 64'(bus.done), 64'd0);
            check("idle_busy", 64'(bus.busy), 64'd0);
         end else begin
            check("done_early", 64'(bus.done), 64'd0);
         end
      end
   endtask

   vec_t tbl [17];

   initial begin
      tbl[0]  = '{4'd3, 5, -7, -64'sd2, 1'b0};
      tbl[1]  = '{4'd4, 10, 3, 64'sd7, 1'b0};
      tbl[2]  = '{4'd2, 0, 9, 64'sd9, 1'b0};
      tbl[3]  = '{4'd1, -100, 4, -64'sd100, 1'b0};
      tbl[4]  = '{4'd0, 12, 13, 64'sd0, 1'b0};
      tbl[5]  = '{4'd5, -4, 6, MD ? -64'sd24 : 64'sd0, !MD};
      tbl[6]  = '{4'd6, 8, 0, 64'sd0, 1'b1};
      tbl[7]  = '{4'd7, -7, 2, MD ? -64'sd1 : 64'sd0, !MD};
      tbl[8]  = '{4'd6, -7, 2, MD ? -64'sd3 : 64'sd0, !MD};
      tbl[9]  = '{4'd5, 2, 3, MD ? 64'sd6 : 64'sd0, !MD};
      tbl[10] = '{4'd9, 1, 1, 64'sd0, 1'b1};
      tbl[11] = '{4'd15, 3, 4, 64'sd0, 1'b1};
      tbl[12] = '{4'd5, 32'sh8000_0000, 32'sh8000_0000,
                  MD ? 64'sh4000_0000_0000_0000 : 64'sd0, !MD};
      tbl[13] = '{4'd3, 32'sh7fff_ffff, 32'sh7fff_ffff, 64'sd4294967294, 1'b0};
      tbl[14] = '{4'd4, 32'sh8000_0000, 1, -64'sd2147483649, 1'b0};
      tbl[15] = '{4'd7, 7, -3, MD ? 64'sd1 : 64'sd0, !MD};
      tbl[16] = '{4'd6, 7, -2, MD ? -64'sd3 : 64'sd0, !MD};

      for (int i = 0; i < N; i++) mem[i] = '0;
      bus.start        = 1'b0;
      bus.start_addr   = '0;
      bus.count        = '0;
      bus.result_ready = 1'b0;
      reset            = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check("rst_read_pointer", 64'(bus.read_pointer), 64'd0);
      check("rst_result", bus.result, 64'd0);
      check("rst_result_addr", 64'(bus.result_addr), 64'd0);
      check("rst_result_err", 64'(bus.result_err), 64'd0);
      check("rst_result_valid", 64'(bus.result_valid), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);

      // Vector table: one entry per address, swept in a single run
      for (int i = 0; i < 17; i++) begin
         mem[i] = {tbl[i].op, tbl[i].a, tbl[i].b};
         push(i, tbl[i].res, tbl[i].err);
      end
      run(0, 17, 0, 0, 1'b0);

      // Single ADD at entry 3
      mem[3] = {4'd3, 32'sd5, -32'sd7};
      push(3, -64'sd2, 1'b0);
      run(3, 1, 0, 0, 1'b0);

      // Wrap from 31 to 0
      mem[30] = {4'd4, 32'sd10, 32'sd3};
      mem[31] = {4'd5, -32'sd4, 32'sd6};
      mem[0]  = {4'd2, 32'sd0, 32'sd9};
      push(30, 64'sd7, 1'b0);
      push(31, MD ? -64'sd24 : 64'sd0, !MD);
      push(0, 64'sd9, 1'b0);
      run(30, 3, 0, 0, 1'b0);

      // Divide by zero, then negative modulo
      mem[0] = {4'd6, 32'sd8, 32'sd0};
      mem[1] = {4'd7, -32'sd7, 32'sd2};
      push(0, 64'sd0, 1'b1);
      push(1, MD ? -64'sd1 : 64'sd0, !MD);
      run(0, 2, 0, 0, 1'b0);

      run(5, 0, 0, 0, 1'b0);

      // Five-cycle backpressure with an ignored start pulse
      mem[10] = {4'd1, 32'sd123, 32'sd0};
      mem[11] = {4'd3, -32'sd1, -32'sd2};
      push(10, 64'sd123, 1'b0);
      push(11, -64'sd3, 1'b0);
      run(10, 2, 5, 5, 1'b1);

      // Reset while the first entry of a 4-entry run is in EXEC
      bus.start        = 1'b1;
      bus.start_addr   = AW'(4);
      bus.count        = (AW+1)'(4);
      bus.result_ready = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_read_pointer", 64'(bus.read_pointer), 64'd0);
      check("mid_rst_result", bus.result, 64'd0);
      check("mid_rst_result_addr", 64'(bus.result_addr), 64'd0);
      check("mid_rst_result_err", 64'(bus.result_err), 64'd0);
      check("mid_rst_valid", 64'(bus.result_valid), 64'd0);
      check("mid_rst_busy", 64'(bus.busy), 64'd0);
      check("mid_rst_done", 64'(bus.done), 64'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("post_rst_quiet", 64'({bus.done, bus.result_valid, bus.busy}), 64'd0);
      end

      // Full sweep of every entry, then random runs
      for (int i = 0; i < N; i++) mem[i] = rand_word();
      for (int i = 0; i < N; i++) exp_q.push_back(model((17 + i) % N));
      run(17, N, 0, 2, 1'b1);

      for (int r = 0; r < 12; r++) begin
         int saddr = int'($urandom_range(0, N - 1));
         int cnt   = int'($urandom_range(1, N));
         for (int i = 0; i < N; i++) mem[i] = rand_word();
         for (int i = 0; i < cnt; i++) exp_q.push_back(model((saddr + i) % N));
         run(saddr, cnt, 0, 3, $urandom_range(0, 1) == 1);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish, %0d/%0d so far", pass_cnt, total_cnt);
      $fatal(1);
   end
endmodule
